// File: rtl/radio_frame_pkg.sv
// Shared definitions for the RX frame-alignment path.
// Contents: tracker state encoding, legal-channel-count check, and the
// expected frame bit for a given slot of the interleave period.
package radio_frame_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } frame_state_e;

  // Period counter width; large enough for lock thresholds up to 255.
  localparam int unsigned PERIOD_CNT_W = 8;

  // Only 1, 2 or 4 time-multiplexed channels are supported on the bus.
  function automatic bit legal_num_chan(input int unsigned num_chan);
    return (num_chan == 32'd1) || (num_chan == 32'd2) || (num_chan == 32'd4);
  endfunction

  // Frame bit is high for the first half of the period, low for the second.
  function automatic logic expected_frame(input int unsigned slot,
                                          input int unsigned num_chan);
    return slot < (num_chan / 32'd2);
  endfunction

endpackage

// File: rtl/radio_frame_slot_tracker.sv
// Frame-alignment tracker: finds slot 0 from the frame pattern, verifies
// LOCK_PERIODS clean periods, then monitors alignment while locked.
// Ports:
//   clk_i, rst_i      clock, async active-high reset
//   en_i              word-consume enable; low forces SEARCH
//   frame_i           frame bit of the current word
//   slot_o            slot index of the current word (valid in VERIFY/LOCKED)
//   period_ok_c       combinational: current word closes a clean locked period
//   locked_o          registered lock flag (high exactly while in LOCKED)
//   lock_lost_o       one-cycle pulse on LOCKED -> SEARCH due to a mismatch
//   err_count_o       saturating count of alignment losses
module radio_frame_slot_tracker
  import radio_frame_pkg::*;
#(
  parameter int unsigned NUM_CHAN     = 2,
  parameter int unsigned LOCK_PERIODS = 4,
  parameter int unsigned ERR_W        = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic                        frame_i,
  output logic [$clog2(NUM_CHAN)-1:0] slot_o,
  output logic                        period_ok_c,
  output logic                        locked_o,
  output logic                        lock_lost_o,
  output logic [ERR_W-1:0]            err_count_o
);

  localparam int unsigned SLOT_W = $clog2(NUM_CHAN);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CHAN - 1);
  localparam logic [PERIOD_CNT_W-1:0] LOCK_LAST = PERIOD_CNT_W'(LOCK_PERIODS - 1);

  frame_state_e             state_q, state_d;
  logic [SLOT_W-1:0]        slot_q, slot_d;
  logic [PERIOD_CNT_W-1:0]  period_q, period_d;
  logic                     frame_d_q, frame_d_d;
  logic                     locked_q, locked_d;
  logic                     lock_lost_q, lock_lost_d;
  logic [ERR_W-1:0]         err_q, err_d;
  logic                     match;
  logic                     last_slot;

  assign match     = (frame_i == expected_frame(32'(slot_q), NUM_CHAN));
  assign last_slot = (slot_q == LAST_SLOT);

  // Next-state, slot/period counters and lock/error bookkeeping.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    period_d    = period_q;
    frame_d_d   = frame_d_q;
    locked_d    = locked_q;
    lock_lost_d = 1'b0;
    err_d       = err_q;
    period_ok_c = 1'b0;

    if (!en_i) begin
      // Disabled: drop back to SEARCH silently; frame history is held.
      state_d  = SEARCH;
      slot_d   = '0;
      locked_d = 1'b0;
    end else begin
      // Every consumed word seeds the edge detector, including mismatch words.
      frame_d_d = frame_i;
      unique case (state_q)
        SEARCH: begin
          if (frame_i && !frame_d_q) begin
            state_d  = VERIFY;
            slot_d   = SLOT_W'(1);
            period_d = '0;
          end
        end
        VERIFY: begin
          if (!match) begin
            state_d = SEARCH;
            slot_d  = '0;
          end else if (last_slot) begin
            slot_d = '0;
            if (period_q == LOCK_LAST) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end else begin
              period_d = period_q + PERIOD_CNT_W'(1);
            end
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
        LOCKED: begin
          if (!match) begin
            state_d     = SEARCH;
            slot_d      = '0;
            locked_d    = 1'b0;
            lock_lost_d = 1'b1;
            if (err_q != {ERR_W{1'b1}}) begin
              err_d = err_q + ERR_W'(1);
            end
          end else if (last_slot) begin
            // Any earlier mismatch would have left LOCKED, so the period is clean.
            slot_d      = '0;
            period_ok_c = 1'b1;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
        default: begin
          state_d = SEARCH;
          slot_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= SEARCH;
      slot_q      <= '0;
      period_q    <= '0;
      frame_d_q   <= 1'b0;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      period_q    <= period_d;
      frame_d_q   <= frame_d_d;
      locked_q    <= locked_d;
      lock_lost_q <= lock_lost_d;
      err_q       <= err_d;
    end
  end

  assign slot_o      = slot_q;
  assign locked_o    = locked_q;
  assign lock_lost_o = lock_lost_q;
  assign err_count_o = err_q;

endmodule

// File: rtl/radio_rx_frame_align.sv
// RX word de-interleaver and frame-alignment tracker (radio_clk domain).
// Collects NUM_CHAN time-multiplexed I/Q words into parallel lanes once the
// frame pattern is locked, and reports lock state and alignment losses.
// Ports:
//   radio_clk, reset   sample clock, async active-high reset
//   enable             low forces SEARCH, suppresses out_valid, holds outputs
//   in_i, in_q         I/Q word of the current slot
//   in_frame           frame bit of the current word
//   out_i, out_q       channel c at [c*WIDTH +: WIDTH]
//   out_valid          one-cycle strobe with a complete aligned set
//   locked             alignment established
//   lock_lost          one-cycle pulse when lock is lost on a mismatch
//   err_count          saturating alignment-loss count
module radio_rx_frame_align
  import radio_frame_pkg::*;
#(
  parameter int unsigned WIDTH        = 12,
  parameter int unsigned NUM_CHAN     = 2,
  parameter int unsigned LOCK_PERIODS = 4,
  parameter int unsigned ERR_W        = 16
) (
  input  logic                      radio_clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [WIDTH-1:0]          in_i,
  input  logic [WIDTH-1:0]          in_q,
  input  logic                      in_frame,
  output logic [NUM_CHAN*WIDTH-1:0] out_i,
  output logic [NUM_CHAN*WIDTH-1:0] out_q,
  output logic                      out_valid,
  output logic                      locked,
  output logic                      lock_lost,
  output logic [ERR_W-1:0]          err_count
);

  localparam int unsigned BUS_W = NUM_CHAN * WIDTH;

  if (!legal_num_chan(NUM_CHAN)) begin : g_bad_num_chan
    $error("radio_rx_frame_align: NUM_CHAN must be 1, 2 or 4");
  end
  if ((LOCK_PERIODS < 1) || (LOCK_PERIODS > 255)) begin : g_bad_lock_periods
    $error("radio_rx_frame_align: LOCK_PERIODS must be within 1..255");
  end

  if (NUM_CHAN == 1) begin : g_single
    // Single channel: no interleave to recover, so frame is ignored.
    logic [BUS_W-1:0] out_i_q, out_q_q;
    logic             out_valid_q;
    logic             locked_q;
    logic             unused_frame;

    assign unused_frame = in_frame;

    always_ff @(posedge radio_clk or posedge reset) begin
      if (reset) begin
        out_i_q     <= '0;
        out_q_q     <= '0;
        out_valid_q <= 1'b0;
        locked_q    <= 1'b0;
      end else begin
        out_valid_q <= enable;
        locked_q    <= enable;
        if (enable) begin
          out_i_q <= in_i;
          out_q_q <= in_q;
        end
      end
    end

    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign out_valid = out_valid_q;
    assign locked    = locked_q;
    assign lock_lost = 1'b0;
    assign err_count = '0;

  end else begin : g_multi
    localparam int unsigned SLOT_W = $clog2(NUM_CHAN);

    logic [SLOT_W-1:0] slot;
    logic              period_ok_c;
    logic              trk_locked;
    logic              trk_lost;
    logic [ERR_W-1:0]  trk_err;
    logic [BUS_W-1:0]  stage_i_q, stage_i_d;
    logic [BUS_W-1:0]  stage_q_q, stage_q_d;
    logic [BUS_W-1:0]  out_i_q, out_i_d;
    logic [BUS_W-1:0]  out_q_q, out_q_d;
    logic              out_valid_q, out_valid_d;

    radio_frame_slot_tracker #(
      .NUM_CHAN     (NUM_CHAN),
      .LOCK_PERIODS (LOCK_PERIODS),
      .ERR_W        (ERR_W)
    ) u_tracker (
      .clk_i       (radio_clk),
      .rst_i       (reset),
      .en_i        (enable),
      .frame_i     (in_frame),
      .slot_o      (slot),
      .period_ok_c (period_ok_c),
      .locked_o    (trk_locked),
      .lock_lost_o (trk_lost),
      .err_count_o (trk_err)
    );

    // Stage words by slot; the last slot is forwarded straight into the output set.
    always_comb begin
      stage_i_d   = stage_i_q;
      stage_q_d   = stage_q_q;
      out_i_d     = out_i_q;
      out_q_d     = out_q_q;
      out_valid_d = 1'b0;
      if (enable && trk_locked) begin
        for (int unsigned c = 0; c < NUM_CHAN; c++) begin
          if (slot == SLOT_W'(c)) begin
            stage_i_d[c*WIDTH +: WIDTH] = in_i;
            stage_q_d[c*WIDTH +: WIDTH] = in_q;
          end
        end
      end
      if (period_ok_c) begin
        out_i_d     = stage_i_d;
        out_q_d     = stage_q_d;
        out_valid_d = 1'b1;
      end
    end

    always_ff @(posedge radio_clk or posedge reset) begin
      if (reset) begin
        stage_i_q   <= '0;
        stage_q_q   <= '0;
        out_i_q     <= '0;
        out_q_q     <= '0;
        out_valid_q <= 1'b0;
      end else begin
        stage_i_q   <= stage_i_d;
        stage_q_q   <= stage_q_d;
        out_i_q     <= out_i_d;
        out_q_q     <= out_q_d;
        out_valid_q <= out_valid_d;
      end
    end

    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign out_valid = out_valid_q;
    assign locked    = trk_locked;
    assign lock_lost = trk_lost;
    assign err_count = trk_err;
  end

endmodule

// File: tb/tb_radio_rx_frame_align.sv
// Self-checking bench for radio_rx_frame_align: four instances cover the
// 2-channel, 4-channel, error-saturation and single-channel configurations.
module tb_radio_rx_frame_align;

  localparam int unsigned W = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- DUT: NUM_CHAN=2, LOCK_PERIODS=4
  logic en2, fr2;
  logic [W-1:0] i2, q2;
  logic [2*W-1:0] oi2, oq2;
  logic ov2, lk2, ll2;
  logic [15:0] ec2;
  radio_rx_frame_align #(.WIDTH(W), .NUM_CHAN(2), .LOCK_PERIODS(4), .ERR_W(16)) u2 (
    .radio_clk(clk), .reset(rst), .enable(en2), .in_i(i2), .in_q(q2), .in_frame(fr2),
    .out_i(oi2), .out_q(oq2), .out_valid(ov2), .locked(lk2), .lock_lost(ll2), .err_count(ec2));

  // ---------------- DUT: NUM_CHAN=4, LOCK_PERIODS=4
  logic en4, fr4;
  logic [W-1:0] i4, q4;
  logic [4*W-1:0] oi4, oq4;
  logic ov4, lk4, ll4;
  logic [15:0] ec4;
  radio_rx_frame_align #(.WIDTH(W), .NUM_CHAN(4), .LOCK_PERIODS(4), .ERR_W(16)) u4 (
    .radio_clk(clk), .reset(rst), .enable(en4), .in_i(i4), .in_q(q4), .in_frame(fr4),
    .out_i(oi4), .out_q(oq4), .out_valid(ov4), .locked(lk4), .lock_lost(ll4), .err_count(ec4));

  // ---------------- DUT: NUM_CHAN=4, LOCK_PERIODS=1, ERR_W=2
  logic en4s, fr4s;
  logic [W-1:0] i4s, q4s;
  logic [4*W-1:0] unused_oi4s, unused_oq4s;
  logic ov4s, lk4s, ll4s;
  logic [1:0] ec4s;
  radio_rx_frame_align #(.WIDTH(W), .NUM_CHAN(4), .LOCK_PERIODS(1), .ERR_W(2)) u4s (
    .radio_clk(clk), .reset(rst), .enable(en4s), .in_i(i4s), .in_q(q4s), .in_frame(fr4s),
    .out_i(unused_oi4s), .out_q(unused_oq4s), .out_valid(ov4s), .locked(lk4s),
    .lock_lost(ll4s), .err_count(ec4s));

  // ---------------- DUT: NUM_CHAN=1
  logic en1, fr1;
  logic [W-1:0] i1, q1;
  logic [W-1:0] oi1, oq1;
  logic ov1, lk1, ll1;
  logic [15:0] ec1;
  radio_rx_frame_align #(.WIDTH(W), .NUM_CHAN(1), .LOCK_PERIODS(4), .ERR_W(16)) u1 (
    .radio_clk(clk), .reset(rst), .enable(en1), .in_i(i1), .in_q(q1), .in_frame(fr1),
    .out_i(oi1), .out_q(oq1), .out_valid(ov1), .locked(lk1), .lock_lost(ll1), .err_count(ec1));

  // ---------------- scoreboards
  typedef struct {
    logic [63:0] oi;
    logic [63:0] oq;
    int unsigned cyc;
  } exp_t;
  exp_t sb2[$];
  exp_t sb4[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ov2) begin
      if (sb2.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL u2_spurious_valid: got out_valid=1 at cycle %0d, required 0", cyc);
      end else begin
        e = sb2.pop_front();
        check("u2_out_i", 64'(oi2), e.oi);
        check("u2_out_q", 64'(oq2), e.oq);
        check("u2_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ov4) begin
      if (sb4.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL u4_spurious_valid: got out_valid=1 at cycle %0d, required 0", cyc);
      end else begin
        e = sb4.pop_front();
        check("u4_out_i", 64'(oi4), e.oi);
        check("u4_out_q", 64'(oq4), e.oq);
        check("u4_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // ---------------- NUM_CHAN=4 word driver with slot history for expectations
  int unsigned tag4 = 0;
  logic [W-1:0] hist_i [4];
  logic [W-1:0] hist_q [4];

  task automatic w4(input bit fr, input int unsigned slot, input bit push);
    en4 = 1'b1;
    fr4 = fr;
    i4  = 12'h400 + 12'(tag4);
    q4  = 12'h800 + 12'(tag4);
    tag4++;
    hist_i[slot] = i4;
    hist_q[slot] = q4;
    if (push)
      sb4.push_back('{oi: 64'({hist_i[3], hist_i[2], hist_i[1], hist_i[0]}),
                      oq: 64'({hist_q[3], hist_q[2], hist_q[1], hist_q[0]}),
                      cyc: cyc + 1});
    tick();
  endtask

  task automatic period4(input bit push);
    w4(1'b1, 0, 1'b0);
    w4(1'b1, 1, 1'b0);
    w4(1'b0, 2, 1'b0);
    w4(1'b0, 3, push);
  endtask

  task automatic w4s(input bit fr);
    en4s = 1'b1;
    fr4s = fr;
    i4s  = 12'($urandom);
    q4s  = 12'($urandom);
    tick();
  endtask

  // ---------------- NUM_CHAN=2 vector table: {enable, frame, locked, lock_lost, push}
  typedef struct packed {
    bit en;
    bit fr;
    bit lk;
    bit ll;
    bit pu;
  } vec_t;
  vec_t tv [17];

  initial begin
    logic [W-1:0] prev_i, prev_q;
    logic [W-1:0] exp_oi1, exp_oq1;
    logic [1:0]   exp_err;

    tv[0]  = 5'b11000;  // rising edge: slot 0 captured
    tv[1]  = 5'b10000;  // period 1 done
    tv[2]  = 5'b11000;
    tv[3]  = 5'b10000;  // period 2
    tv[4]  = 5'b11000;
    tv[5]  = 5'b10000;  // period 3
    tv[6]  = 5'b11000;
    tv[7]  = 5'b10100;  // period 4 -> locked
    tv[8]  = 5'b11100;
    tv[9]  = 5'b10101;  // first output set
    tv[10] = 5'b11100;
    tv[11] = 5'b10101;
    tv[12] = 5'b01000;  // enable dropped 3 cycles
    tv[13] = 5'b00000;
    tv[14] = 5'b01000;
    tv[15] = 5'b11000;  // re-capture from held frame history
    tv[16] = 5'b10000;

    rst = 1'b1;
    en2 = 1'b0; fr2 = 1'b0; i2 = '0; q2 = '0;
    en4 = 1'b0; fr4 = 1'b0; i4 = '0; q4 = '0;
    en4s = 1'b0; fr4s = 1'b0; i4s = '0; q4s = '0;
    en1 = 1'b0; fr1 = 1'b0; i1 = '0; q1 = '0;
    prev_i = '0; prev_q = '0;
    exp_oi1 = '0; exp_oq1 = '0;
    repeat (2) tick();

    // Reset values
    check("rst_u2_out_i", 64'(oi2), 64'd0);
    check("rst_u2_valid", 64'(ov2), 64'd0);
    check("rst_u2_locked", 64'(lk2), 64'd0);
    check("rst_u2_err", 64'(ec2), 64'd0);
    check("rst_u4_lost", 64'(ll4), 64'd0);
    check("rst_u1_locked", 64'(lk1), 64'd0);
    rst = 1'b0;
    tick();

    // NUM_CHAN=2 lock-up, data, enable drop
    for (int r = 0; r < 17; r++) begin
      en2 = tv[r].en;
      fr2 = tv[r].fr;
      i2  = 12'h100 + 12'(r);
      q2  = 12'h200 + 12'(r);
      if (tv[r].pu)
        sb2.push_back('{oi: 64'({i2, prev_i}), oq: 64'({q2, prev_q}), cyc: cyc + 1});
      tick();
      check($sformatf("t1_locked[%0d]", r), 64'(lk2), 64'(tv[r].lk));
      check($sformatf("t1_lock_lost[%0d]", r), 64'(ll2), 64'(tv[r].ll));
      prev_i = i2;
      prev_q = q2;
    end
    check("t1_err_after_enable_drop", 64'(ec2), 64'd0);
    en2 = 1'b0;

    // NUM_CHAN=4 stream starting at slot 3
    w4(1'b0, 3, 1'b0);
    check("t4_not_locked_mid", 64'(lk4), 64'd0);
    for (int p = 0; p < 4; p++) begin
      period4(1'b0);
      check($sformatf("t4_locked_p%0d", p), 64'(lk4), (p == 3) ? 64'd1 : 64'd0);
    end
    period4(1'b1);
    period4(1'b1);
    check("t2_err_before", 64'(ec4), 64'd0);

    // Bad frame at slot 2 while locked
    w4(1'b1, 0, 1'b0);
    w4(1'b1, 1, 1'b0);
    w4(1'b1, 2, 1'b0);
    check("t2_lock_lost_pulse", 64'(ll4), 64'd1);
    check("t2_locked_dropped", 64'(lk4), 64'd0);
    check("t2_err_inc", 64'(ec4), 64'd1);
    w4(1'b0, 3, 1'b0);
    check("t2_lock_lost_one_cycle", 64'(ll4), 64'd0);
    for (int p = 0; p < 4; p++) begin
      period4(1'b0);
      check($sformatf("t2_relock_p%0d", p), 64'(lk4), (p == 3) ? 64'd1 : 64'd0);
    end
    period4(1'b1);
    check("t2_err_hold", 64'(ec4), 64'd1);

    // Error saturation, ERR_W=2
    for (int k = 0; k < 5; k++) begin
      w4s(1'b1); w4s(1'b1); w4s(1'b0); w4s(1'b0);
      check($sformatf("t3_locked[%0d]", k), 64'(lk4s), 64'd1);
      w4s(1'b1); w4s(1'b1); w4s(1'b1);
      exp_err = (k >= 2) ? 2'd3 : 2'(k + 1);
      check($sformatf("t3_err[%0d]", k), 64'(ec4s), 64'(exp_err));
      check($sformatf("t3_lost[%0d]", k), 64'(ll4s), 64'd1);
      check($sformatf("t3_no_valid[%0d]", k), 64'(ov4s), 64'd0);
      w4s(1'b0);
    end
    en4s = 1'b0;

    // Reset pulsed mid-period while locked
    w4(1'b1, 0, 1'b0);
    w4(1'b1, 1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_out_i", 64'(oi4), 64'd0);
    check("t5_rst_out_q", 64'(oq4), 64'd0);
    check("t5_rst_locked", 64'(lk4), 64'd0);
    check("t5_rst_err", 64'(ec4), 64'd0);
    check("t5_rst_valid", 64'(ov4), 64'd0);
    en4 = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // NUM_CHAN=1 with random frame and occasional enable gaps
    for (int k = 0; k < 40; k++) begin
      en1 = ($urandom_range(0, 4) != 0);
      fr1 = 1'($urandom);
      i1  = 12'($urandom);
      q1  = 12'($urandom);
      tick();
      if (en1) begin
        exp_oi1 = i1;
        exp_oq1 = q1;
      end
      check($sformatf("t6_valid[%0d]", k), 64'(ov1), 64'(en1));
      check($sformatf("t6_locked[%0d]", k), 64'(lk1), 64'(en1));
      check($sformatf("t6_out_i[%0d]", k), 64'(oi1), 64'(exp_oi1));
      check($sformatf("t6_out_q[%0d]", k), 64'(oq1), 64'(exp_oq1));
      check($sformatf("t6_err[%0d]", k), 64'({ec1, ll1}), 64'd0);
    end
    en1 = 1'b0;
    tick();

    check("sb2_drained", 64'(sb2.size()), 64'd0);
    check("sb4_drained", 64'(sb4.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
